// File: rtl/display_command_processor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : display_command_processor
// Turns fill / clear / palette commands into framebuffer and palette writes.
// Rev    : 1.0  initial release
// ============================================================================
module display_command_processor #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 12,
    parameter int LANES          = 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    output logic [31:0]                       status_o,
    input  logic [31:0]                       control_i,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic [1:0]                        cmd_op_i,
    input  logic [15:0]                       cmd_x0_i,
    input  logic [15:0]                       cmd_x1_i,
    input  logic [15:0]                       cmd_y0_i,
    input  logic [15:0]                       cmd_y1_i,
    input  logic [$clog2(PALETTE_LENGTH)-1:0] cmd_index_i,
    input  logic [COLOR_BITS-1:0]             cmd_color_i,
    output logic [$clog2(RESOLUTION_X)-1:0]   fb_wr_x_o,
    output logic [$clog2(RESOLUTION_Y)-1:0]   fb_wr_y_o,
    output logic [$clog2(PALETTE_LENGTH)-1:0] fb_wr_index_o,
    output logic [LANES-1:0]                  fb_wr_mask_o,
    output logic                              fb_wr_en_o,
    output logic [$clog2(PALETTE_LENGTH)-1:0] palette_wr_index_o,
    output logic [COLOR_BITS-1:0]             palette_wr_color_o,
    output logic                              palette_wr_en_o
);
    localparam int XW = $clog2(RESOLUTION_X);
    localparam int YW = $clog2(RESOLUTION_Y);
    localparam int IW = $clog2(PALETTE_LENGTH);
    localparam logic [15:0] X_MAX = 16'(RESOLUTION_X - 1);
    localparam logic [15:0] Y_MAX = 16'(RESOLUTION_Y - 1);
    localparam logic [1:0]  OP_NOP = 2'd0;
    localparam logic [1:0]  OP_PAL = 2'd2;
    localparam logic [1:0]  OP_CLR = 2'd3;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_PALETTE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
    logic [YW-1:0]   y1_q, y1_d, cur_y_q, cur_y_d;
    logic [IW-1:0]   index_q, index_d;
    logic [COLOR_BITS-1:0] color_q, color_d;
    logic [15:0]     count_q, count_d;
    logic            error_q, error_d, aborted_q, aborted_d;
    logic [XW-1:0]   fb_x_q, fb_x_d;
    logic [YW-1:0]   fb_y_q, fb_y_d;
    logic [IW-1:0]   fb_idx_q, fb_idx_d;
    logic [LANES-1:0] fb_mask_q, fb_mask_d;
    logic            fb_en_q, fb_en_d;
    logic [IW-1:0]   pal_idx_q, pal_idx_d;
    logic [COLOR_BITS-1:0] pal_col_q, pal_col_d;
    logic            pal_en_q, pal_en_d;

    logic [15:0]     w_rx0, w_rx1, w_ry0, w_ry1;
    logic            w_bad, w_accept, w_row_done;
    logic [XW:0]     w_next_x;
    logic            w_unused_ctrl;

    assign w_unused_ctrl = &{1'b0, control_i[31:2]};
    assign cmd_ready_o   = (state_q == ST_IDLE) & ~control_i[0] & ~reset_i;
    assign w_accept      = cmd_valid_i & cmd_ready_o;
    assign w_next_x      = {1'b0, cur_x_q} + (XW+1)'(LANES);
    assign w_row_done    = w_next_x > {1'b0, x1_q};

    // CLEAR is a full-screen fill; far corners are clamped before validation
    always_comb begin
        w_rx0 = cmd_x0_i;
        w_ry0 = cmd_y0_i;
        w_rx1 = (cmd_x1_i > X_MAX) ? X_MAX : cmd_x1_i;
        w_ry1 = (cmd_y1_i > Y_MAX) ? Y_MAX : cmd_y1_i;
        if (cmd_op_i == OP_CLR) begin
            w_rx0 = '0;
            w_ry0 = '0;
            w_rx1 = X_MAX;
            w_ry1 = Y_MAX;
        end
        w_bad = (w_rx0 > X_MAX) | (w_ry0 > Y_MAX) | (w_rx0 > w_rx1) | (w_ry0 > w_ry1);
    end

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        index_d   = index_q;
        color_d   = color_q;
        count_d   = count_q;
        error_d   = error_q & ~control_i[1];
        aborted_d = aborted_q & ~control_i[1];
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_op_i == OP_NOP) begin
                        count_d = count_q + 16'd1;
                    end else if (cmd_op_i == OP_PAL) begin
                        index_d = cmd_index_i;
                        color_d = cmd_color_i;
                        state_d = ST_PALETTE;
                    end else if (w_bad) begin
                        error_d = 1'b1;
                    end else begin
                        x0_d    = w_rx0[XW-1:0];
                        x1_d    = w_rx1[XW-1:0];
                        y1_d    = w_ry1[YW-1:0];
                        cur_x_d = w_rx0[XW-1:0];
                        cur_y_d = w_ry0[YW-1:0];
                        index_d = cmd_index_i;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (control_i[0]) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (w_row_done) begin
                    cur_x_d = x0_q;
                    if (cur_y_q == y1_q) begin
                        count_d = count_q + 16'd1;
                        state_d = ST_IDLE;
                    end else begin
                        cur_y_d = cur_y_q + YW'(1);
                    end
                end else begin
                    cur_x_d = w_next_x[XW-1:0];
                end
            end
            ST_PALETTE: begin
                count_d = count_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Write ports are loaded from the next position so the first write
        // appears the cycle after the accepting edge.
        fb_en_d   = (state_d == ST_FILL);
        fb_x_d    = fb_en_d ? cur_x_d : '0;
        fb_y_d    = fb_en_d ? cur_y_d : '0;
        fb_idx_d  = fb_en_d ? index_d : '0;
        for (int k = 0; k < LANES; k++) begin
            fb_mask_d[k] = fb_en_d && (({1'b0, cur_x_d} + (XW+1)'(k)) <= {1'b0, x1_d});
        end
        pal_en_d  = (state_d == ST_PALETTE);
        pal_idx_d = pal_en_d ? index_d : '0;
        pal_col_d = pal_en_d ? color_d : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            index_q   <= '0;
            color_q   <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            fb_x_q    <= '0;
            fb_y_q    <= '0;
            fb_idx_q  <= '0;
            fb_mask_q <= '0;
            fb_en_q   <= 1'b0;
            pal_idx_q <= '0;
            pal_col_q <= '0;
            pal_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            index_q   <= index_d;
            color_q   <= color_d;
            count_q   <= count_d;
            error_q   <= error_d;
            aborted_q <= aborted_d;
            fb_x_q    <= fb_x_d;
            fb_y_q    <= fb_y_d;
            fb_idx_q  <= fb_idx_d;
            fb_mask_q <= fb_mask_d;
            fb_en_q   <= fb_en_d;
            pal_idx_q <= pal_idx_d;
            pal_col_q <= pal_col_d;
            pal_en_q  <= pal_en_d;
        end
    end

    assign status_o           = {count_q, 13'd0, aborted_q, error_q, (state_q != ST_IDLE)};
    assign fb_wr_x_o          = fb_x_q;
    assign fb_wr_y_o          = fb_y_q;
    assign fb_wr_index_o      = fb_idx_q;
    assign fb_wr_mask_o       = fb_mask_q;
    assign fb_wr_en_o         = fb_en_q;
    assign palette_wr_index_o = pal_idx_q;
    assign palette_wr_color_o = pal_col_q;
    assign palette_wr_en_o    = pal_en_q;
endmodule
`default_nettype wire

// File: tb/tb_display_command_processor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_display_command_processor
// Drives a LANES=1 and a LANES=4 instance against a rectangle-list model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_display_command_processor;
    localparam int RX = 400;
    localparam int RY = 300;

    typedef struct packed {logic [8:0] x; logic [8:0] y; logic [7:0] idx; logic [3:0] mask;} wr_t;
    typedef struct packed {logic [7:0] idx; logic [11:0] color;} pw_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] control = '0;
    logic [1:0]  valid = '0;
    logic [1:0]  op = '0;
    logic [15:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic [7:0]  idx = '0;
    logic [11:0] color = '0;

    logic [31:0] st_a, st_b;
    logic        rdy_a, rdy_b, fe_a, fe_b, pe_a, pe_b;
    logic [8:0]  fx_a, fx_b, fy_a, fy_b;
    logic [7:0]  fi_a, fi_b, pi_a, pi_b;
    logic [0:0]  fm_a;
    logic [3:0]  fm_b;
    logic [11:0] pc_a, pc_b;

    always #5 clk = ~clk;

    display_command_processor #(.LANES(1)) dut_a (
        .clk_i(clk), .reset_i(reset), .status_o(st_a), .control_i(control),
        .cmd_valid_i(valid[0]), .cmd_ready_o(rdy_a), .cmd_op_i(op),
        .cmd_x0_i(x0), .cmd_x1_i(x1), .cmd_y0_i(y0), .cmd_y1_i(y1),
        .cmd_index_i(idx), .cmd_color_i(color),
        .fb_wr_x_o(fx_a), .fb_wr_y_o(fy_a), .fb_wr_index_o(fi_a), .fb_wr_mask_o(fm_a),
        .fb_wr_en_o(fe_a), .palette_wr_index_o(pi_a), .palette_wr_color_o(pc_a),
        .palette_wr_en_o(pe_a)
    );

    display_command_processor #(.LANES(4)) dut_b (
        .clk_i(clk), .reset_i(reset), .status_o(st_b), .control_i(control),
        .cmd_valid_i(valid[1]), .cmd_ready_o(rdy_b), .cmd_op_i(op),
        .cmd_x0_i(x0), .cmd_x1_i(x1), .cmd_y0_i(y0), .cmd_y1_i(y1),
        .cmd_index_i(idx), .cmd_color_i(color),
        .fb_wr_x_o(fx_b), .fb_wr_y_o(fy_b), .fb_wr_index_o(fi_b), .fb_wr_mask_o(fm_b),
        .fb_wr_en_o(fe_b), .palette_wr_index_o(pi_b), .palette_wr_color_o(pc_b),
        .palette_wr_en_o(pe_b)
    );

    // Write-stream recorder, sampled mid-cycle
    wr_t qa[$], qb[$];
    pw_t pa[$], pb[$];
    int  ta[$], tb[$];
    int  cyc = 0, busy_a = 0, busy_b = 0, idle_viol = 0;

    always @(negedge clk) begin
        cyc++;
        if (fe_a) begin qa.push_back(wr_t'({fx_a, fy_a, fi_a, 3'b000, fm_a})); ta.push_back(cyc); end
        if (fe_b) begin qb.push_back(wr_t'({fx_b, fy_b, fi_b, fm_b})); tb.push_back(cyc); end
        if (pe_a) pa.push_back(pw_t'({pi_a, pc_a}));
        if (pe_b) pb.push_back(pw_t'({pi_b, pc_b}));
        if (!fe_a && {fx_a, fy_a, fi_a, fm_a} != '0) idle_viol++;
        if (!fe_b && {fx_b, fy_b, fi_b, fm_b} != '0) idle_viol++;
        if (!pe_a && {pi_a, pc_a} != '0) idle_viol++;
        if (!pe_b && {pi_b, pc_b} != '0) idle_viol++;
        if (st_a[0]) busy_a++;
        if (st_b[0]) busy_b++;
    end

    int  checks = 0, fails = 0;
    int  ca = 0, cb = 0;
    wr_t exp_q[$], got_q[$];
    pw_t got_p[$];
    int  got_t[$];
    int  got_busy;

    // Reference: enumerate the rectangle row by row in LANES-wide chunks
    function automatic bit model(input int lanes, input int o, input int ax0, input int ax1,
                                 input int ay0, input int ay1, input int ix);
        int cx1, cy1;
        wr_t w;
        logic [3:0] m;
        exp_q.delete();
        if (o == 3) begin ax0 = 0; ay0 = 0; ax1 = RX - 1; ay1 = RY - 1; end
        cx1 = (ax1 > RX - 1) ? RX - 1 : ax1;
        cy1 = (ay1 > RY - 1) ? RY - 1 : ay1;
        if (ax0 >= RX || ay0 >= RY || ax0 > cx1 || ay0 > cy1) return 1'b1;
        for (int y = ay0; y <= cy1; y++) begin
            for (int x = ax0; x <= cx1; x += lanes) begin
                m = '0;
                for (int k = 0; k < lanes; k++) m[k] = (x + k <= cx1);
                w.x = 9'(x); w.y = 9'(y); w.idx = 8'(ix); w.mask = m;
                exp_q.push_back(w);
            end
        end
        return 1'b0;
    endfunction

    task automatic do_cmd(input int sel, input int o, input int ax0, input int ax1, input int ay0,
                          input int ay1, input int ix, input int col, output bit ok);
        int n, s, sp, sb;
        s  = sel ? qb.size() : qa.size();
        sp = sel ? pb.size() : pa.size();
        sb = sel ? busy_b : busy_a;
        got_q.delete(); got_t.delete(); got_p.delete();
        op = 2'(o); x0 = 16'(ax0); x1 = 16'(ax1); y0 = 16'(ay0); y1 = 16'(ay1);
        idx = 8'(ix); color = 12'(col);
        n = 0;
        while ((sel ? rdy_b : rdy_a) !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        valid[sel] = 1'b1;
        @(posedge clk); #1;
        valid = '0;
        n = 0;
        while ((sel ? st_b[0] : st_a[0]) !== 1'b0 && n < 40000) begin @(posedge clk); #1; n++; end
        ok = (n < 40000);
        @(posedge clk); #1;
        if (sel) begin
            for (int i = s; i < qb.size(); i++) begin got_q.push_back(qb[i]); got_t.push_back(tb[i]); end
            for (int i = sp; i < pb.size(); i++) got_p.push_back(pb[i]);
            got_busy = busy_b - sb;
        end else begin
            for (int i = s; i < qa.size(); i++) begin got_q.push_back(qa[i]); got_t.push_back(ta[i]); end
            for (int i = sp; i < pa.size(); i++) got_p.push_back(pa[i]);
            got_busy = busy_a - sb;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if ({rdy_a, rdy_b} !== 2'b00) begin fails++; $display("FAIL reset_ready_low: got %b required 00", {rdy_a, rdy_b}); end
        #10;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (st_a !== 32'd0) begin fails++; $display("FAIL reset_status_a: got %h required 0", st_a); end
        checks++;
        if (st_b !== 32'd0) begin fails++; $display("FAIL reset_status_b: got %h required 0", st_b); end
        checks++;
        if ({fe_a, fx_a, fy_a, fi_a, fm_a, pe_a, pi_a, pc_a} !== '0) begin
            fails++; $display("FAIL reset_outputs_a: nonzero write outputs");
        end
        checks++;
        if ({fe_b, fx_b, fy_b, fi_b, fm_b, pe_b, pi_b, pc_b} !== '0) begin
            fails++; $display("FAIL reset_outputs_b: nonzero write outputs");
        end
        checks++;
        if ({rdy_a, rdy_b} !== 2'b11) begin fails++; $display("FAIL reset_ready_high: got %b required 11", {rdy_a, rdy_b}); end
    endtask

    task automatic test_fill_lane1();
        bit ok, err;
        do_cmd(0, 1, 2, 5, 3, 4, 7, 0, ok);
        err = model(1, 1, 2, 5, 3, 4, 7);
        if (!err) ca++;
        checks++;
        if (!ok) begin fails++; $display("FAIL fill1_timeout: busy did not drop"); end
        checks++;
        if (got_q.size() != 8) begin fails++; $display("FAIL fill1_count: got %0d writes required 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL fill1_write%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (got_t.size() == 8 && got_t[7] - got_t[0] != 7) begin
            fails++; $display("FAIL fill1_back_to_back: span %0d required 7", got_t[7] - got_t[0]);
        end
        checks++;
        if (got_busy != 8) begin fails++; $display("FAIL fill1_busy: got %0d cycles required 8", got_busy); end
        checks++;
        if (st_a[31:16] !== 16'(ca)) begin fails++; $display("FAIL fill1_cmd_count: got %0d required %0d", st_a[31:16], ca); end
    endtask

    task automatic test_fill_lane4_and_clear();
        bit ok, err;
        int bad;
        int ix;
        ix = int'($urandom_range(0, 255));
        do_cmd(1, 1, 1, 6, 0, 0, ix, 0, ok);
        err = model(4, 1, 1, 6, 0, 0, ix);
        if (!err) cb++;
        checks++;
        if (got_q.size() != 2) begin fails++; $display("FAIL fill4_count: got %0d writes required 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL fill4_write%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        ix = int'($urandom_range(0, 255));
        do_cmd(1, 3, 77, 3, 91, 2, ix, 0, ok);
        err = model(4, 3, 77, 3, 91, 2, ix);
        if (!err) cb++;
        checks++;
        if (!ok) begin fails++; $display("FAIL clear_timeout: busy did not drop"); end
        checks++;
        if (got_q.size() != 30000) begin fails++; $display("FAIL clear_count: got %0d writes required 30000", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL clear_content: %0d writes differ, required 0", bad); end
        checks++;
        if (got_q.size() > 0 && {got_q[$].x, got_q[$].y, got_q[$].mask} !== {9'd396, 9'd299, 4'hF}) begin
            fails++; $display("FAIL clear_last: got x=%0d y=%0d mask=%h required 396 299 f", got_q[$].x, got_q[$].y, got_q[$].mask);
        end
        checks++;
        if (got_busy != 30000) begin fails++; $display("FAIL clear_busy: got %0d required 30000", got_busy); end
        checks++;
        if (st_b[31:16] !== 16'(cb)) begin fails++; $display("FAIL clear_cmd_count: got %0d required %0d", st_b[31:16], cb); end
    endtask

    task automatic test_palette();
        bit ok;
        do_cmd(0, 2, 0, 0, 0, 0, 255, 'hF0A, ok);
        ca++;
        checks++;
        if (got_p.size() != 1) begin fails++; $display("FAIL pal_pulses: got %0d required 1", got_p.size()); end
        checks++;
        if (got_p.size() > 0 && got_p[0] !== pw_t'({8'd255, 12'hF0A})) begin
            fails++; $display("FAIL pal_data: got %h required ff/f0a", got_p[0]);
        end
        checks++;
        if (got_q.size() != 0) begin fails++; $display("FAIL pal_no_fb: got %0d fb writes required 0", got_q.size()); end
        checks++;
        if (st_a[31:16] !== 16'(ca)) begin fails++; $display("FAIL pal_cmd_count: got %0d required %0d", st_a[31:16], ca); end
    endtask

    task automatic test_error_and_clamp();
        bit ok, err;
        do_cmd(0, 1, 10, 5, 0, 0, 3, 0, ok);
        checks++;
        if (st_a[1] !== 1'b1) begin fails++; $display("FAIL err_flag: got %b required 1", st_a[1]); end
        checks++;
        if (got_q.size() != 0) begin fails++; $display("FAIL err_no_writes: got %0d required 0", got_q.size()); end
        checks++;
        if (st_a[31:16] !== 16'(ca)) begin fails++; $display("FAIL err_cmd_count: got %0d required %0d", st_a[31:16], ca); end
        do_cmd(0, 1, 398, 1000, 0, 0, 9, 0, ok);
        err = model(1, 1, 398, 1000, 0, 0, 9);
        if (!err) ca++;
        checks++;
        if (got_q.size() != 2) begin fails++; $display("FAIL clamp_count: got %0d required 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL clamp_write%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (st_a[1] !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b required 1", st_a[1]); end
        control = 32'd2;
        @(posedge clk); #1;
        control = '0;
        checks++;
        if (st_a[2:1] !== 2'b00) begin fails++; $display("FAIL err_clear: got %b required 00", st_a[2:1]); end
    endtask

    task automatic test_abort();
        int s, n;
        s = qa.size();
        op = 2'd1; x0 = 16'd0; x1 = 16'd19; y0 = 16'd5; y1 = 16'd5; idx = 8'd42;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid = '0;
        n = 0;
        while (qa.size() < s + 3 && n < 50) begin @(negedge clk); #1; n++; end
        control = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n >= 50) begin fails++; $display("FAIL abort_timeout: third write never seen"); end
        checks++;
        if (qa.size() != s + 3) begin fails++; $display("FAIL abort_writes: got %0d required 3", qa.size() - s); end
        checks++;
        if (st_a[2:0] !== 3'b100) begin fails++; $display("FAIL abort_flags: got %b required 100", st_a[2:0]); end
        checks++;
        if (rdy_a !== 1'b0) begin fails++; $display("FAIL abort_blocks_ready: got %b required 0", rdy_a); end
        checks++;
        if (st_a[31:16] !== 16'(ca)) begin fails++; $display("FAIL abort_cmd_count: got %0d required %0d", st_a[31:16], ca); end
        control = '0;
        #1;
        checks++;
        if (rdy_a !== 1'b1) begin fails++; $display("FAIL abort_ready_back: got %b required 1", rdy_a); end
        control = 32'd2;
        @(posedge clk); #1;
        control = '0;
        checks++;
        if (st_a[2:1] !== 2'b00) begin fails++; $display("FAIL abort_clear: got %b required 00", st_a[2:1]); end
    endtask

    task automatic test_random();
        bit ok, err;
        int sel, r, o, ax0, ax1, ay0, ay1, ix, col, bad, cnt;
        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 7));
            o   = (r == 0) ? 0 : (r == 1) ? 2 : 1;
            ax0 = int'($urandom_range(0, RX + 5));
            ax1 = ax0 + int'($urandom_range(0, 12)) - 2;
            ay0 = int'($urandom_range(0, RY + 3));
            ay1 = ay0 + int'($urandom_range(0, 3)) - 1;
            if (r == 7) begin ax1 = ax0 + 600; ay1 = ay0; end
            if (ax1 < 0) ax1 = 0;
            if (ay1 < 0) ay1 = 0;
            ix  = int'($urandom_range(0, 255));
            col = int'($urandom_range(0, 4095));
            do_cmd(sel, o, ax0, ax1, ay0, ay1, ix, col, ok);
            err = (o == 1) ? model(sel ? 4 : 1, o, ax0, ax1, ay0, ay1, ix) : 1'b0;
            if (o != 1) exp_q.delete();
            if (!err) begin if (sel != 0) cb++; else ca++; end
            cnt = sel ? cb : ca;
            checks++;
            if (got_q.size() != exp_q.size()) begin
                fails++; $display("FAIL rand%0d_count: got %0d writes required %0d", it, got_q.size(), exp_q.size());
            end
            bad = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
            checks++;
            if (bad != 0) begin fails++; $display("FAIL rand%0d_content: %0d writes differ", it, bad); end
            checks++;
            if ((sel ? st_b[1] : st_a[1]) !== err) begin
                fails++; $display("FAIL rand%0d_error: got %b required %b", it, sel ? st_b[1] : st_a[1], err);
            end
            checks++;
            if ((sel ? st_b[31:16] : st_a[31:16]) !== 16'(cnt)) begin
                fails++; $display("FAIL rand%0d_cmd_count: got %0d required %0d", it, sel ? st_b[31:16] : st_a[31:16], cnt);
            end
            checks++;
            if (got_p.size() != ((o == 2) ? 1 : 0) || (o == 2 && got_p[0] !== pw_t'({8'(ix), 12'(col)}))) begin
                fails++; $display("FAIL rand%0d_palette: got %0d pulses required %0d", it, got_p.size(), (o == 2) ? 1 : 0);
            end
            control = 32'd2;
            @(posedge clk); #1;
            control = '0;
        end
    endtask

    task automatic test_idle_outputs_zero();
        checks++;
        if (idle_viol != 0) begin fails++; $display("FAIL idle_outputs_zero: got %0d violations required 0", idle_viol); end
    endtask

    initial begin
        test_reset();
        test_fill_lane1();
        test_fill_lane4_and_clear();
        test_palette();
        test_error_and_clamp();
        test_abort();
        test_random();
        test_idle_outputs_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
